jk_decoder: RTL and testbench
=============================

Name: jk_decoder

Overview:
- USB full-speed receive-side line decoder. Companion to the transmit-side J/K encoder.
- Samples dp/dn at 48 MHz (4x oversampled, 12 Mb/s) and recovers bit timing from line transitions.
- Hunts for SYNC, NRZI-decodes payload bits and removes stuffed bits.
- Detects EOP and line errors, delivering one strobed bit at a time to the packet layer.

Parameters:
- SAMPLE_PHASE, 2: phase-counter value (0..3) at which the line is sampled.
- SYNC_MIN_ZEROS, 5: minimum decoded 0 bits before the closing 1 for SYNC to be accepted.
- IDLE_RECOVER_BITS, 7: consecutive J samples needed in ERR_WAIT to return to IDLE.

Ports:
- clk48  input  1  48 MHz clock.
- reset_n  input  1  asynchronous active-low reset.
- dp  input  1  D+ line.
- dn  input  1  D- line.
- bit_out  output  1  decoded payload bit; valid only when bit_valid=1.
- bit_valid  output  1  one-cycle strobe per delivered payload bit.
- packet_start  output  1  one-cycle strobe when SYNC is accepted.
- done  output  1  one-cycle strobe when a valid EOP completes.
- error  output  1  one-cycle strobe on stuff error, SE1, or bad EOP.
- active  output  1  high from SYNC acceptance until done/error.

Behaviour:
- Reset: one clock; reset is asynchronous, active-low (reset_n). All outputs 0, state IDLE, counters 0, prev_line=J. Reset asserted mid-packet aborts immediately; no done/error is emitted.
- Line states: J=(dp1,dn0), K=(0,1), SE0=(0,0), SE1=(1,1).
- Phase counter (2 bits):
  - Set to 0 in any cycle the line state differs from the previous cycle's line state; otherwise increments, wrapping 3->0.
  - A sample is taken when phase==SAMPLE_PHASE. Drift of ±1 clock per bit is absorbed because every transition resynchronises the counter.
  - In IDLE the counter is held at 0 until a J->K transition.
- NRZI: decoded bit = 1 if the sample equals prev_sample, 0 if it differs. prev_sample updates on every sample.
- States:
  - IDLE: on J->K transition, go to SYNC. prev_sample=J, zero_cnt=0.
  - SYNC: each sample:
    - 0 -> zero_cnt++ (saturating at 7).
    - 1 with zero_cnt>=SYNC_MIN_ZEROS -> pulse packet_start, active=1, ones_cnt=0, go to PAYLOAD.
    - 1 with fewer zeros -> IDLE.
    - SE0 or SE1 -> IDLE, no strobe.
  - PAYLOAD: each sample:
    - SE0 -> go to EOP, se0_cnt=1.
    - SE1 -> error, go to ERR_WAIT.
    - Decoded 0 with ones_cnt==6 -> stuffed bit: dropped, no bit_valid, ones_cnt=0.
    - Decoded 1 with ones_cnt==6 -> stuff error: pulse error, active=0, go to ERR_WAIT.
    - Otherwise -> bit_out=bit, bit_valid pulse. ones_cnt increments on 1, clears on 0.
  - EOP: each sample:
    - SE0 -> se0_cnt++ (saturating at 3).
    - J with se0_cnt>=1 -> pulse done, active=0, go to IDLE.
    - K or SE1 -> pulse error, active=0, go to ERR_WAIT.
  - ERR_WAIT: count consecutive J samples; any non-J clears the count. Count reaching IDLE_RECOVER_BITS -> IDLE. No strobes while in ERR_WAIT.
- Latency: strobes are registered and assert the cycle after the deciding sample. From a dp/dn edge to the bit_valid carrying the bit that edge defines: 2 (synchroniser) + SAMPLE_PHASE + 1 = 5 clk48 cycles.
- Outputs are mutually exclusive per cycle. A stuffed-bit drop and the last bit before SE0 produce no extra strobe.
- The first payload bit is the bit after the SYNC closing 1. SYNC bits are never delivered.

Optional Feature:
- Macro JK_DECODER_INPUT_SYNC_EN.
- Defined: dp/dn pass through a 2-flop synchroniser, reset to J, before all logic. Latency is as stated above.
- Undefined: dp/dn are assumed synchronous to clk48 and used directly. All latencies are reduced by 2 cycles; behaviour is otherwise identical.

Test Plan:
- KJKJKJKK, then byte 0xA5 LSB-first NRZI-encoded, then SE0 SE0 J -> packet_start once; 8 bit_valid with bits 1,0,1,0,0,1,0,1; done once; error never.
- SYNC then 0xFF with a stuffed 0 after 6 ones, then EOP -> exactly 8 bit_valid all 1; stuffed bit not delivered; done.
- SYNC then 7 consecutive 1s with no stuff bit -> 6 bit_valid; error pulse on the 7th; then J held 7 bits -> back in IDLE; the next valid packet decodes correctly.
- Bit period alternating 3/5 clk48 cycles at transitions over 0x3C -> bits 0,0,1,1,1,1,0,0 decoded correctly.
- SE0 after KJKJ during SYNC -> no packet_start, no error; state IDLE.
- reset_n pulsed low for 1 cycle mid-payload -> all outputs 0 within the same cycle; no done/error; a following packet decodes normally.

Source files
------------

// File: rtl/jk_decoder.sv
// jk_decoder: USB full-speed receive line decoder (phase recovery, SYNC hunt, NRZI decode, unstuffing, EOP)
// Optional JK_DECODER_INPUT_SYNC_EN: dp/dn pass through a 2-flop synchroniser (reset to J) before all logic.
module jk_decoder #(
  parameter int SAMPLE_PHASE      = 2,
  parameter int SYNC_MIN_ZEROS    = 5,
  parameter int IDLE_RECOVER_BITS = 7
) (
  input  logic clk48,
  input  logic reset_n,
  input  logic dp,
  input  logic dn,
  output logic bit_out,
  output logic bit_valid,
  output logic packet_start,
  output logic done,
  output logic error,
  output logic active
);
  localparam logic [1:0] J   = 2'b10;
  localparam logic [1:0] K   = 2'b01;
  localparam logic [1:0] SE0 = 2'b00;
  localparam logic [1:0] SE1 = 2'b11;
  localparam logic [1:0] LP_PHASE = 2'(SAMPLE_PHASE);
  localparam logic [2:0] LP_ZMIN  = 3'(SYNC_MIN_ZEROS);
  localparam logic [3:0] LP_JLAST = 4'(IDLE_RECOVER_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_PAYLOAD, S_EOP, S_ERR_WAIT} state_t;

  state_t     r_state;
  logic [1:0] w_line;
  logic [1:0] r_prev_line;
  logic [1:0] r_prev_sample;
  logic [1:0] r_phase;
  logic [1:0] w_phase;
  logic [2:0] r_zero_cnt;
  logic [2:0] r_ones_cnt;
  logic [1:0] r_se0_cnt;
  logic [3:0] r_j_cnt;
  logic       w_sample;
  logic       w_bit;
  logic       w_se;

`ifdef JK_DECODER_INPUT_SYNC_EN
  logic [1:0] r_sync1;
  logic [1:0] r_sync2;

  // two-flop synchroniser for the asynchronous line, idling at J
  always_ff @(posedge clk48 or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= J;
      r_sync2 <= J;
    end else begin
      r_sync1 <= {dp, dn};
      r_sync2 <= r_sync1;
    end
  end

  assign w_line = r_sync2;
`else
  assign w_line = {dp, dn};
`endif

  // any line change resynchronises the bit-phase counter
  assign w_phase  = (w_line != r_prev_line) ? 2'd0 : r_phase + 2'd1;
  assign w_sample = (r_state != S_IDLE) && (w_phase == LP_PHASE);
  assign w_bit    = (w_line == r_prev_sample);
  assign w_se     = (w_line == SE0) || (w_line == SE1);

  // decode state machine with registered strobes and active flag
  always_ff @(posedge clk48 or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_prev_line   <= J;
      r_prev_sample <= J;
      r_phase       <= 2'd0;
      r_zero_cnt    <= 3'd0;
      r_ones_cnt    <= 3'd0;
      r_se0_cnt     <= 2'd0;
      r_j_cnt       <= 4'd0;
      bit_out       <= 1'b0;
      bit_valid     <= 1'b0;
      packet_start  <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      active        <= 1'b0;
    end else begin
      r_prev_line  <= w_line;
      r_phase      <= (r_state == S_IDLE) ? 2'd0 : w_phase;
      bit_valid    <= 1'b0;
      packet_start <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      if (w_sample) r_prev_sample <= w_line;
      case (r_state)
        S_IDLE: begin
          if (r_prev_line == J && w_line == K) begin
            r_state       <= S_SYNC;
            r_prev_sample <= J;
            r_zero_cnt    <= 3'd0;
          end
        end
        S_SYNC: begin
          if (w_sample) begin
            if (w_se) begin
              r_state <= S_IDLE;
            end else if (!w_bit) begin
              r_zero_cnt <= (r_zero_cnt == 3'd7) ? 3'd7 : r_zero_cnt + 3'd1;
            end else if (r_zero_cnt >= LP_ZMIN) begin
              packet_start <= 1'b1;
              active       <= 1'b1;
              r_ones_cnt   <= 3'd0;
              r_state      <= S_PAYLOAD;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        S_PAYLOAD: begin
          if (w_sample) begin
            if (w_line == SE0) begin
              r_se0_cnt <= 2'd1;
              r_state   <= S_EOP;
            end else if (w_line == SE1 || (r_ones_cnt == 3'd6 && w_bit)) begin
              error   <= 1'b1;
              active  <= 1'b0;
              r_j_cnt <= 4'd0;
              r_state <= S_ERR_WAIT;
            end else if (r_ones_cnt == 3'd6) begin
              r_ones_cnt <= 3'd0;
            end else begin
              bit_out    <= w_bit;
              bit_valid  <= 1'b1;
              r_ones_cnt <= w_bit ? r_ones_cnt + 3'd1 : 3'd0;
            end
          end
        end
        S_EOP: begin
          if (w_sample) begin
            if (w_line == SE0) begin
              r_se0_cnt <= (r_se0_cnt == 2'd3) ? 2'd3 : r_se0_cnt + 2'd1;
            end else if (w_line == J) begin
              if (r_se0_cnt != 2'd0) begin
                done    <= 1'b1;
                active  <= 1'b0;
                r_state <= S_IDLE;
              end
            end else begin
              error   <= 1'b1;
              active  <= 1'b0;
              r_j_cnt <= 4'd0;
              r_state <= S_ERR_WAIT;
            end
          end
        end
        S_ERR_WAIT: begin
          if (w_sample) begin
            if (w_line != J) begin
              r_j_cnt <= 4'd0;
            end else if (r_j_cnt == LP_JLAST) begin
              r_j_cnt <= 4'd0;
              r_state <= S_IDLE;
            end else begin
              r_j_cnt <= r_j_cnt + 4'd1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_jk_decoder.sv
// tb_jk_decoder: table-driven packet vectors plus hand-written corner sequences for jk_decoder
module tb_jk_decoder;
  localparam logic [1:0] J   = 2'b10;
  localparam logic [1:0] K   = 2'b01;
  localparam logic [1:0] SE0 = 2'b00;
`ifdef JK_DECODER_INPUT_SYNC_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 3;
`endif

  logic clk48 = 1'b0;
  logic reset_n = 1'b1;
  logic dp = 1'b1;
  logic dn = 1'b0;
  logic bit_out, bit_valid, packet_start, done, error, active;

  always #10 clk48 = ~clk48;

  jk_decoder dut (
    .clk48(clk48), .reset_n(reset_n), .dp(dp), .dn(dn),
    .bit_out(bit_out), .bit_valid(bit_valid), .packet_start(packet_start),
    .done(done), .error(error), .active(active)
  );

  typedef struct {
    logic [15:0] raw;
    int          nraw;
    bit          drift;
    logic [15:0] exp_bits;
    int          exp_n;
  } vec_t;

  vec_t vecs[6];
  int   n_ps = 0, n_valid = 0, n_done = 0, n_err = 0, n_multi = 0;
  logic hist[$];
  int   passed = 0, total = 0;
  logic [1:0] lvl;

  always @(negedge clk48) begin
    if (int'(bit_valid) + int'(packet_start) + int'(done) + int'(error) > 1) n_multi++;
    if (packet_start) n_ps++;
    if (done) n_done++;
    if (error) n_err++;
    if (bit_valid) begin
      hist.push_back(bit_out);
      n_valid++;
    end
  end

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  task automatic drive(input logic [1:0] s, input int n);
    {dp, dn} = s;
    repeat (n) @(posedge clk48);
    #1;
  endtask

  task automatic send_sync();
    logic [1:0] seq [8];
    seq = '{K, J, K, J, K, J, K, K};
    for (int i = 0; i < 8; i++) drive(seq[i], 4);
    lvl = K;
  endtask

  task automatic send_bits(input logic [15:0] raw, input int n, input bit drift);
    bit alt;
    int d;
    alt = 1'b0;
    for (int i = 0; i < n; i++) begin
      d = 4;
      if (!raw[i]) begin
        lvl = (lvl == J) ? K : J;
        if (drift) begin
          d = alt ? 5 : 3;
          alt = !alt;
        end
      end
      drive(lvl, d);
    end
  endtask

  task automatic send_eop();
    drive(SE0, 8);
    drive(J, 16);
    lvl = J;
  endtask

  task automatic check_bits(input string name, input int base, input int n, input logic [15:0] exp);
    logic [15:0] g;
    g = '0;
    for (int i = 0; i < n && i < 16; i++)
      if (base + i < hist.size()) g[i] = hist[base + i];
    check(name, int'(g), int'(exp));
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int b_ps, b_v, b_d, b_e;
    drive(J, 8);
    b_ps = n_ps; b_v = n_valid; b_d = n_done; b_e = n_err;
    send_sync();
    send_bits(v.raw, v.nraw, v.drift);
    send_eop();
    check({tag, "_start"}, n_ps - b_ps, 1);
    check({tag, "_nvalid"}, n_valid - b_v, v.exp_n);
    check_bits({tag, "_bits"}, b_v, v.exp_n, v.exp_bits);
    check({tag, "_done"}, n_done - b_d, 1);
    check({tag, "_err"}, n_err - b_e, 0);
    check({tag, "_active"}, int'(active), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int b_ps, b_v, b_d, b_e, lat;
    logic seen;
    vecs[0] = '{16'h00A5, 8,  1'b0, 16'h00A5, 8};
    vecs[1] = '{16'h01BF, 9,  1'b0, 16'h00FF, 8};
    vecs[2] = '{16'h003C, 8,  1'b1, 16'h003C, 8};
    vecs[3] = '{16'h0000, 8,  1'b0, 16'h0000, 8};
    vecs[4] = '{16'h003F, 6,  1'b0, 16'h003F, 6};
    vecs[5] = '{16'h017E, 10, 1'b0, 16'h00FE, 9};
    lvl = J;
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk48);
    #1;
    check("reset_outs", int'({bit_out, bit_valid, packet_start, done, error, active}), 0);
    reset_n = 1'b1;
    drive(J, 8);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // stuff error: seven ones without a stuff bit, then J recovery
    drive(J, 8);
    b_ps = n_ps; b_v = n_valid; b_d = n_done; b_e = n_err;
    send_sync();
    send_bits(16'h007F, 7, 1'b0);
    check("stufferr_nvalid", n_valid - b_v, 6);
    check_bits("stufferr_bits", b_v, 6, 16'h003F);
    check("stufferr_err", n_err - b_e, 1);
    check("stufferr_active", int'(active), 0);
    drive(J, 32);
    lvl = J;
    check("stufferr_done", n_done - b_d, 0);
    check("stufferr_start", n_ps - b_ps, 1);
    check("stufferr_err_once", n_err - b_e, 1);
    run_vec(vecs[0], "after_err");

    // SE0 during SYNC abandons the hunt silently
    drive(J, 8);
    b_ps = n_ps; b_v = n_valid; b_d = n_done; b_e = n_err;
    drive(K, 4); drive(J, 4); drive(K, 4); drive(J, 4);
    drive(SE0, 8);
    drive(J, 16);
    lvl = J;
    check("se0sync_start", n_ps - b_ps, 0);
    check("se0sync_err", n_err - b_e, 0);
    check("se0sync_done", n_done - b_d, 0);
    check("se0sync_valid", n_valid - b_v, 0);
    check("se0sync_active", int'(active), 0);
    run_vec(vecs[3], "after_se0");

    // edge-to-strobe latency of the first payload bit
    drive(J, 8);
    b_v = n_valid; b_d = n_done;
    send_sync();
    {dp, dn} = J;
    lvl = J;
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      @(posedge clk48);
      lat++;
      @(negedge clk48);
      seen = bit_valid;
    end
    check("lat_cycles", lat, LAT);
    check("lat_bit", int'(bit_out), 0);
    check("lat_active", int'(active), 1);
    @(posedge clk48);
    #1;
    send_eop();
    check("lat_nvalid", n_valid - b_v, 1);
    check("lat_done", n_done - b_d, 1);

    // reset mid-payload aborts with no done/error
    drive(J, 8);
    send_sync();
    send_bits(16'h0005, 3, 1'b0);
    check("rst_active_before", int'(active), 1);
    @(negedge clk48);
    #2 reset_n = 1'b0;
    #1;
    check("rst_outs", int'({bit_out, bit_valid, packet_start, done, error, active}), 0);
    @(negedge clk48);
    reset_n = 1'b1;
    b_ps = n_ps; b_v = n_valid; b_d = n_done; b_e = n_err;
    @(posedge clk48);
    #1;
    drive(J, 40);
    lvl = J;
    check("rst_done", n_done - b_d, 0);
    check("rst_err", n_err - b_e, 0);
    check("rst_valid", n_valid - b_v, 0);
    run_vec(vecs[0], "after_rst");

    check("exclusive_strobes", n_multi, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
